// File: rtl/uart_program_loader.sv
// uart_program_loader: takes a SYNC_BYTE header and then a 2**ADDR_WIDTH-byte image over UART 8N1.
// It writes the image to RAM and holds the CPU in reset until the load completes. Optional macro: UART_LOADER_CHECKSUM_EN.
module uart_program_loader #(
    parameter int         CLK_FREQ_HZ  = 27_000_000,
    parameter int         BAUD         = 115_200,
    parameter int         ADDR_WIDTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [7:0]            prog_data,
    output logic                  prog_we,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CNT_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]  HALF_LAST = BIT_CNT_W'(HALF_BIT - 1);
    localparam logic [TO_CNT_W-1:0]   TO_LAST   = TO_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_CHECK, L_DONE} ld_state_t;
`else
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;
`endif

    logic                  sync_p0, sync_p1, line_p2;
    logic                  rx_fall;
    rx_state_t             rx_state, rx_state_next;
    logic [BIT_CNT_W-1:0]  rx_cnt;
    logic [2:0]            rx_bit;
    logic [7:0]            rx_shift;
    logic [7:0]            rx_byte;
    logic                  rx_valid, rx_ferr;

    ld_state_t             ld_state, ld_state_next;
    logic [ADDR_WIDTH-1:0] ld_cnt;
    logic [TO_CNT_W-1:0]   to_cnt;
    logic                  ld_active, timed_out;
    logic                  ld_start, ld_write, ld_finish, ld_abort;

    // Stage p0/p1: metastability synchroniser; p2 holds the previous line level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
        end else begin
            sync_p0 <= uart_rx;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
        end
    end

    assign rx_fall = line_p2 & ~sync_p1;
    assign rx_byte = rx_shift;

    always_comb begin
        rx_state_next = rx_state;
        rx_valid      = 1'b0;
        rx_ferr       = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_next = sync_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_state_next = RX_IDLE;
                    rx_valid      = sync_p1;
                    rx_ferr       = ~sync_p1;
                end
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_next;
            if (rx_state == RX_IDLE || rx_state != rx_state_next || rx_cnt == BIT_LAST)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + BIT_CNT_W'(1);
            if (rx_state == RX_IDLE)
                rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_cnt == BIT_LAST)
                rx_bit <= rx_bit + 3'd1;
        end
    end

    // LSB arrives first, so each sample enters at the top and walks down
    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_cnt == BIT_LAST)
            rx_shift <= {sync_p1, rx_shift[7:1]};
    end

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] ck_sum;
    assign ld_active = (ld_state == L_LOAD) || (ld_state == L_CHECK);
    always_ff @(posedge clk) begin
        if (ld_start)
            ck_sum <= '0;
        else if (ld_write)
            ck_sum <= ck_sum + rx_byte;
    end
`else
    assign ld_active = (ld_state == L_LOAD);
`endif
    assign timed_out = (to_cnt == TO_LAST);

    always_comb begin
        ld_state_next = ld_state;
        ld_start      = 1'b0;
        ld_write      = 1'b0;
        ld_finish     = 1'b0;
        ld_abort      = 1'b0;
        case (ld_state)
            L_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    ld_state_next = L_LOAD;
                    ld_start      = 1'b1;
                end
            end
            L_LOAD: begin
                if (rx_valid) begin
                    ld_write = 1'b1;
                    if (ld_cnt == LAST_ADDR) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        ld_state_next = L_CHECK;
`else
                        ld_state_next = L_DONE;
                        ld_finish     = 1'b1;
`endif
                    end
                end else if (rx_ferr || timed_out) begin
                    ld_state_next = L_IDLE;
                    ld_abort      = 1'b1;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            L_CHECK: begin
                if (rx_valid && rx_byte == ck_sum) begin
                    ld_state_next = L_DONE;
                    ld_finish     = 1'b1;
                end else if (rx_valid || rx_ferr || timed_out) begin
                    ld_state_next = L_IDLE;
                    ld_abort      = 1'b1;
                end
            end
`endif
            L_DONE:  ld_state_next = L_IDLE;
            default: ld_state_next = L_IDLE;
        endcase
    end

    // Status flags are registered on the transition edge; cpu_hold survives an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state  <= L_IDLE;
            ld_cnt    <= '0;
            to_cnt    <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_we   <= 1'b0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            ld_state <= ld_state_next;
            prog_we  <= ld_write;
            if (ld_write) begin
                prog_addr <= ld_cnt;
                prog_data <= rx_byte;
                if (ld_cnt != LAST_ADDR)
                    ld_cnt <= ld_cnt + ADDR_WIDTH'(1);
            end
            if (rx_valid || !ld_active)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_CNT_W'(1);
            if (ld_start) begin
                ld_cnt   <= '0;
                busy     <= 1'b1;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
            end
            if (ld_finish) begin
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
            end
            if (ld_abort) begin
                busy  <= 1'b0;
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table-driven and randomized loads, with write contents
// checked against a queue-based image model. Honours UART_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_program_loader;
    localparam int         CLK_FREQ_HZ  = 1_000_000;
    localparam int         BAUD         = 100_000;
    localparam int         ADDR_WIDTH   = 4;
    localparam int         TIMEOUT_BITS = 32;
    localparam int         CPB          = CLK_FREQ_HZ / BAUD;
    localparam int         IMG          = 1 << ADDR_WIDTH;
    localparam logic [7:0] SYNC         = 8'hA5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  uart_rx = 1'b1;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [7:0]            prog_data;
    logic                  prog_we, cpu_hold, busy, done, error;

    uart_program_loader #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .ADDR_WIDTH(ADDR_WIDTH),
        .SYNC_BYTE(SYNC), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int we_run = 0;
    int we_long = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prog_we) begin
            wr_addr.push_back(int'(prog_addr));
            wr_data.push_back(int'(prog_data));
            wr_cyc.push_back(cyc);
            we_run = we_run + 1;
            if (we_run > 1) we_long = we_long + 1;
        end else begin
            we_run = 0;
        end
    end

    typedef struct {
        int n;
        int bad;
        bit ramp;
        int a5_at;
        int exp_wr;
        bit exp_done;
        bit exp_err;
        bit exp_hold;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        we_long = 0;
    endtask

    // Outcome of a load from the rules: writes stop at a framing error, at the image end, or at the last byte sent
    function automatic void model(input int n, input int bad, output int w, output bit d, output bit e);
        int accepted;
        accepted = (bad >= 0 && bad < n) ? bad : n;
        w = (accepted > IMG) ? IMG : accepted;
        d = (w == IMG);
        e = !d;
    endfunction

    task automatic run_load(input string tag, input int n, input int bad, input bit ramp, input int a5_at,
                            input int exp_wr, input bit exp_done, input bit exp_err, input bit exp_hold);
        logic [7:0] img[$];
        logic [7:0] b;
        logic [7:0] sum;
        int         t_first;
        int         lat;
        int         lim;
        clear_log();
        sum = 8'h00;
        t_first = 0;
        send_byte(SYNC, 1'b1);
        wait_clks(2 * CPB);
        chk({tag, "_busy_after_sync"}, busy, 1);
        chk({tag, "_hold_after_sync"}, cpu_hold, 1);
        chk({tag, "_err_cleared"}, error, 0);
        for (int k = 0; k < n; k++) begin
            b = ramp ? 8'(k) : 8'($urandom);
            if (k == a5_at) b = SYNC;
            img.push_back(b);
            sum = sum + b;
            @(negedge clk);
            if (k == 0) t_first = cyc;
            send_byte(b, k != bad);
            if (k == bad) break;
            wait_clks(2 * CPB);
        end
`ifdef UART_LOADER_CHECKSUM_EN
        if (n == IMG && bad < 0) begin
            send_byte(sum, 1'b1);
            wait_clks(2 * CPB);
        end
`endif
        wait_clks(250);
        if (exp_err && bad < 0) chk({tag, "_no_early_timeout"}, error, 0);
        wait_clks(150);
        chk({tag, "_write_count"}, wr_addr.size(), exp_wr);
        lim = (wr_addr.size() < exp_wr) ? wr_addr.size() : exp_wr;
        for (int k = 0; k < lim; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wr_addr[k], k);
            chk($sformatf("%s_data%0d", tag, k), wr_data[k], int'(img[k]));
        end
        if (exp_wr > 0 && wr_cyc.size() > 0) begin
            lat = wr_cyc[0] - t_first;
            checks++;
            if (lat < 95 || lat > 100) begin
                failures++;
                $display("FAIL %s_first_write_latency: got %0d expected 95..100", tag, lat);
            end
        end
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_hold"}, cpu_hold, exp_hold);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we_single_cycle"}, we_long, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   n, bad, w;
        bit   d, e;

        vecs[0] = '{n: 16, bad: -1, ramp: 1'b1, a5_at: -1, exp_wr: 16, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
        vecs[1] = '{n: 5,  bad: -1, ramp: 1'b0, a5_at: -1, exp_wr: 5,  exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
        vecs[2] = '{n: 16, bad: -1, ramp: 1'b0, a5_at: 2,  exp_wr: 16, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
        vecs[3] = '{n: 4,  bad: 3,  ramp: 1'b0, a5_at: -1, exp_wr: 3,  exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
        vecs[4] = '{n: 0,  bad: -1, ramp: 1'b0, a5_at: -1, exp_wr: 0,  exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
        vecs[5] = '{n: 16, bad: 15, ramp: 1'b0, a5_at: -1, exp_wr: 15, exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
        vecs[6] = '{n: 16, bad: -1, ramp: 1'b0, a5_at: 0,  exp_wr: 16, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};

        // Reset, then an idle line
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        clear_log();
        wait_clks(100);
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_we", prog_we, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_no_writes", wr_addr.size(), 0);

        // Non-sync byte and a short low glitch while idle
        send_byte(8'h3C, 1'b1);
        wait_clks(2 * CPB);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        wait_clks(100);
        chk("idle_ignore_writes", wr_addr.size(), 0);
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_hold", cpu_hold, 0);

        for (int i = 0; i < 7; i++)
            run_load($sformatf("vec%0d", i), vecs[i].n, vecs[i].bad, vecs[i].ramp, vecs[i].a5_at,
                     vecs[i].exp_wr, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_hold);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(0, IMG);
            bad = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            model(n, bad, w, d, e);
            run_load($sformatf("rnd%0d", r), n, bad, 1'b0, -1, w, d, e, e);
        end

        // Reset in the middle of a load
        clear_log();
        send_byte(SYNC, 1'b1);
        wait_clks(2 * CPB);
        for (int k = 0; k < 8; k++) begin
            send_byte(8'($urandom), 1'b1);
            if (k < 7) wait_clks(2 * CPB);
        end
        wait_clks(1);
        chk("midrst_writes_before", wr_addr.size(), 8);
        @(negedge clk);
        rst = 1'b1;
        wait_clks(1);
        chk("midrst_addr", prog_addr, 0);
        chk("midrst_data", prog_data, 0);
        chk("midrst_we", prog_we, 0);
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_clks(400);
        chk("midrst_no_more_writes", wr_addr.size(), 8);
        chk("midrst_no_error", error, 0);
        run_load("after_rst", IMG, -1, 1'b0, -1, IMG, 1'b1, 1'b0, 1'b0);

        // Checksum byte handling (or its absence)
        clear_log();
        send_byte(SYNC, 1'b1);
        wait_clks(2 * CPB);
        for (int k = 0; k < IMG; k++) begin
            send_byte(8'h01, 1'b1);
            wait_clks(2 * CPB);
        end
`ifdef UART_LOADER_CHECKSUM_EN
        chk("ck_pending_done", done, 0);
        chk("ck_pending_busy", busy, 1);
        send_byte(8'h10, 1'b1);
        wait_clks(2 * CPB);
        chk("ck_good_done", done, 1);
        chk("ck_good_hold", cpu_hold, 0);
        chk("ck_good_writes", wr_addr.size(), IMG);
        clear_log();
        send_byte(SYNC, 1'b1);
        wait_clks(2 * CPB);
        for (int k = 0; k < IMG; k++) begin
            send_byte(8'h01, 1'b1);
            wait_clks(2 * CPB);
        end
        send_byte(8'h11, 1'b1);
        wait_clks(2 * CPB);
        chk("ck_bad_error", error, 1);
        chk("ck_bad_hold", cpu_hold, 1);
        chk("ck_bad_done", done, 0);
        chk("ck_bad_writes", wr_addr.size(), IMG);
`else
        chk("nock_done", done, 1);
        chk("nock_hold", cpu_hold, 0);
        send_byte(8'h10, 1'b1);
        wait_clks(2 * CPB);
        chk("nock_extra_ignored", wr_addr.size(), IMG);
        chk("nock_still_done", done, 1);
        chk("nock_busy", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
